// File: rtl/penalty_pkg.sv
// Shared definitions for the penalty tracker: state encoding and datapath widths.
package penalty_pkg;

  localparam int PENALTY_W = 4;
  localparam int TIMER_W   = 8;

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    COOLDOWN = 2'd1,
    OVER     = 2'd2
  } state_t;

endpackage

// File: rtl/penalty_timer.sv
// Loadable, tick-enabled 8-bit down-counter with a zero flag; shared by the
// cooldown window and the game-over blink period.
module penalty_timer
  import penalty_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  input  logic               i_tick,
  output logic [TIMER_W-1:0] o_count,
  output logic               o_zero
);

  logic [TIMER_W-1:0] r_count;

  // Load wins over decrement so an expiring blink period restarts cleanly.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - TIMER_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/penalty_tracker.sv
// Penalty counter with post-foul cooldown and game-over detection.
// Define PENALTY_BLINK_EN to blink the penalty markers while in game-over.
module penalty_tracker
  import penalty_pkg::*;
#(
  parameter int MAX_PENALTY    = 3,
  parameter int COOLDOWN_TICKS = 8,
  parameter int BLINK_TICKS    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 foul,
  input  logic                 new_round,
  output logic [PENALTY_W-1:0] penalty_num,
  output logic                 foul_ack,
  output logic                 game_over,
  output logic                 blink_on
);

  localparam logic [PENALTY_W-1:0] MAX_P  = PENALTY_W'(MAX_PENALTY);
  localparam logic [TIMER_W-1:0]   COOL_T = TIMER_W'(COOLDOWN_TICKS);
`ifdef PENALTY_BLINK_EN
  localparam logic [TIMER_W-1:0]   BLINK_T = TIMER_W'(BLINK_TICKS);
`endif

  if (MAX_PENALTY < 1 || MAX_PENALTY > 15 || COOLDOWN_TICKS < 1 || COOLDOWN_TICKS > 255 ||
      BLINK_TICKS < 1 || BLINK_TICKS > 255) begin : g_bad_params
    $error("penalty_tracker: parameter out of range");
  end

  state_t               r_state;
  logic [PENALTY_W-1:0] r_penalty;
  logic                 r_foul_ack;
  logic                 r_game_over;
  logic                 r_blink;

  logic [TIMER_W-1:0]   w_timer_count;
  logic                 w_timer_zero;
  logic                 w_timer_load;
  logic [TIMER_W-1:0]   w_timer_load_val;
  logic                 w_timer_tick;
  logic [PENALTY_W-1:0] w_next_penalty;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_expire;

  assign w_next_penalty = (r_penalty < MAX_P) ? (r_penalty + PENALTY_W'(1)) : MAX_P;
  assign w_accept       = (r_state == PLAY) && foul && !new_round;
  assign w_last         = (w_next_penalty >= MAX_P);
  // A tick expires the timer when it takes the count from 1 to 0.
  assign w_expire       = tick && (w_timer_zero || (w_timer_count == TIMER_W'(1)));

  always_comb begin
    w_timer_load     = 1'b0;
    w_timer_load_val = COOL_T;
    w_timer_tick     = 1'b0;
    if (!new_round) begin
      case (r_state)
        PLAY: begin
          if (w_accept) begin
`ifdef PENALTY_BLINK_EN
            w_timer_load     = 1'b1;
            w_timer_load_val = w_last ? BLINK_T : COOL_T;
`else
            w_timer_load     = !w_last;
`endif
          end
        end
        COOLDOWN: w_timer_tick = tick;
`ifdef PENALTY_BLINK_EN
        OVER: begin
          w_timer_tick = tick;
          if (w_expire) begin
            w_timer_load     = 1'b1;
            w_timer_load_val = BLINK_T;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  penalty_timer u_timer (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_clear    (new_round),
    .i_load     (w_timer_load),
    .i_load_val (w_timer_load_val),
    .i_tick     (w_timer_tick),
    .o_count    (w_timer_count),
    .o_zero     (w_timer_zero)
  );

  // new_round returns to the same state as reset, dropping any same-cycle foul.
  always_ff @(posedge clk) begin
    if (reset || new_round) begin
      r_state     <= PLAY;
      r_penalty   <= '0;
      r_foul_ack  <= 1'b0;
      r_game_over <= 1'b0;
      r_blink     <= 1'b1;
    end else begin
      r_foul_ack <= 1'b0;
      case (r_state)
        PLAY: begin
          if (w_accept) begin
            r_penalty  <= w_next_penalty;
            r_foul_ack <= 1'b1;
            if (w_last) begin
              r_state     <= OVER;
              r_game_over <= 1'b1;
              r_blink     <= 1'b1;
            end else begin
              r_state <= COOLDOWN;
            end
          end
        end
        COOLDOWN: begin
          if (w_expire) r_state <= PLAY;
        end
        OVER: begin
`ifdef PENALTY_BLINK_EN
          if (w_expire) r_blink <= !r_blink;
`endif
        end
        default: r_state <= PLAY;
      endcase
    end
  end

  assign penalty_num = r_penalty;
  assign foul_ack    = r_foul_ack;
  assign game_over   = r_game_over;
  assign blink_on    = r_blink;

endmodule

// File: tb/tb_penalty_tracker.sv
// Self-checking bench for penalty_tracker: directed scenarios plus a randomized
// run against a behavioural model. Build with PENALTY_BLINK_EN to check blinking.
`timescale 1ns/1ps
module tb_penalty_tracker;

  localparam int MAXP  = 3;
  localparam int COOL  = 8;
  localparam int BLINK = 4;
`ifdef PENALTY_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, tick, foul, new_round;
  logic [3:0] penalty_num;
  logic       foul_ack, game_over, blink_on;

  int nChecks = 0;
  int nFails  = 0;

  // Behavioural model: penalties, remaining cooldown ticks, ticks spent in game-over.
  int mPen, mCool, mOverTicks;
  bit mAck;

  always #5 clk = ~clk;

  penalty_tracker #(
    .MAX_PENALTY    (MAXP),
    .COOLDOWN_TICKS (COOL),
    .BLINK_TICKS    (BLINK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .foul        (foul),
    .new_round   (new_round),
    .penalty_num (penalty_num),
    .foul_ack    (foul_ack),
    .game_over   (game_over),
    .blink_on    (blink_on)
  );

  // Advance the model by one clock using the rules of the tracker.
  task automatic modelStep(input bit rst, input bit nr, input bit fl, input bit tk);
    mAck = 1'b0;
    if (rst || nr) begin
      mPen = 0; mCool = 0; mOverTicks = 0;
    end else if (mPen == MAXP) begin
      if (tk) mOverTicks++;
    end else if (mCool > 0) begin
      if (tk) mCool--;
    end else if (fl) begin
      mPen++;
      mAck = 1'b1;
      mCool = (mPen == MAXP) ? 0 : COOL;
      mOverTicks = 0;
    end
  endtask

  function automatic bit expBlink();
    return !BLINK_EN || (((mOverTicks / BLINK) % 2) == 0);
  endfunction

  // Drive one cycle of inputs, clock it, update the model, then settle for sampling.
  task automatic applyStimulus(input bit rst, input bit nr, input bit fl, input bit tk);
    reset = rst; new_round = nr; foul = fl; tick = tk;
    @(posedge clk);
    modelStep(rst, nr, fl, tk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1, 1, 1, 1);
    applyStimulus(1, 0, 0, 0);
    nChecks++; if (penalty_num !== 4'd0) begin nFails++; $display("[TB] FAIL reset_count: got %0d, expected 0", penalty_num); end
    nChecks++; if (foul_ack !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ack: got %b, expected 0", foul_ack); end
    nChecks++; if (game_over !== 1'b0) begin nFails++; $display("[TB] FAIL reset_game_over: got %b, expected 0", game_over); end
    nChecks++; if (blink_on !== 1'b1) begin nFails++; $display("[TB] FAIL reset_blink: got %b, expected 1", blink_on); end
  endtask

  task automatic test_first_foul();
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    nChecks++; if (penalty_num !== 4'd1) begin nFails++; $display("[TB] FAIL first_foul_count: got %0d, expected 1", penalty_num); end
    nChecks++; if (foul_ack !== 1'b1) begin nFails++; $display("[TB] FAIL first_foul_ack: got %b, expected 1", foul_ack); end
    applyStimulus(0, 0, 0, 0);
    nChecks++; if (foul_ack !== 1'b0) begin nFails++; $display("[TB] FAIL ack_one_cycle: got %b, expected 0", foul_ack); end
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0);
    nChecks++; if (penalty_num !== 4'd1) begin nFails++; $display("[TB] FAIL cooldown_drop_count: got %0d, expected 1", penalty_num); end
    nChecks++; if (foul_ack !== 1'b0) begin nFails++; $display("[TB] FAIL cooldown_drop_ack: got %b, expected 0", foul_ack); end
  endtask

  task automatic test_game_over();
    applyStimulus(1, 0, 0, 0);
    for (int f = 0; f < MAXP; f++) begin
      if (f > 0) for (int t = 0; t < COOL; t++) applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 1, 0);
      nChecks++; if (foul_ack !== 1'b1) begin nFails++; $display("[TB] FAIL spaced_foul_ack[%0d]: got %b, expected 1", f, foul_ack); end
    end
    nChecks++; if (penalty_num !== 4'd3) begin nFails++; $display("[TB] FAIL over_count: got %0d, expected 3", penalty_num); end
    nChecks++; if (game_over !== 1'b1) begin nFails++; $display("[TB] FAIL over_flag: got %b, expected 1", game_over); end
    nChecks++; if (blink_on !== 1'b1) begin nFails++; $display("[TB] FAIL over_blink_entry: got %b, expected 1", blink_on); end
    applyStimulus(0, 0, 1, 0);
    nChecks++; if (penalty_num !== 4'd3) begin nFails++; $display("[TB] FAIL over_saturate: got %0d, expected 3", penalty_num); end
    nChecks++; if (foul_ack !== 1'b0) begin nFails++; $display("[TB] FAIL over_drop_ack: got %b, expected 0", foul_ack); end
  endtask

  // Runs straight after test_game_over, so the tracker is fresh in game-over.
  task automatic test_blink();
    for (int t = 1; t <= 2 * BLINK; t++) begin
      applyStimulus(0, 0, 0, 1);
      if (t == BLINK - 1) begin
        nChecks++; if (blink_on !== 1'b1) begin nFails++; $display("[TB] FAIL blink_before_toggle: got %b, expected 1", blink_on); end
      end
      if (t == BLINK) begin
        nChecks++; if (blink_on !== !BLINK_EN) begin nFails++; $display("[TB] FAIL blink_first_toggle: got %b, expected %b", blink_on, !BLINK_EN); end
      end
      if (t == 2 * BLINK) begin
        nChecks++; if (blink_on !== 1'b1) begin nFails++; $display("[TB] FAIL blink_second_toggle: got %b, expected 1", blink_on); end
      end
    end
    nChecks++; if (game_over !== 1'b1) begin nFails++; $display("[TB] FAIL blink_still_over: got %b, expected 1", game_over); end
  endtask

  task automatic test_new_round_priority();
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    for (int t = 0; t < COOL; t++) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0);
    for (int t = 0; t < COOL; t++) applyStimulus(0, 0, 0, 1);
    nChecks++; if (penalty_num !== 4'd2) begin nFails++; $display("[TB] FAIL nr_setup_count: got %0d, expected 2", penalty_num); end
    applyStimulus(0, 1, 1, 0);
    nChecks++; if (penalty_num !== 4'd0) begin nFails++; $display("[TB] FAIL nr_clear_count: got %0d, expected 0", penalty_num); end
    nChecks++; if (foul_ack !== 1'b0) begin nFails++; $display("[TB] FAIL nr_drop_ack: got %b, expected 0", foul_ack); end
    applyStimulus(0, 0, 1, 0);
    nChecks++; if (penalty_num !== 4'd1 || foul_ack !== 1'b1) begin nFails++; $display("[TB] FAIL nr_back_to_play: got count %0d ack %b, expected count 1 ack 1", penalty_num, foul_ack); end
  endtask

  task automatic test_reset_mid_state();
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    for (int t = 0; t < 3; t++) applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 1, 1, 1);
    nChecks++; if (penalty_num !== 4'd0 || foul_ack !== 1'b0 || game_over !== 1'b0 || blink_on !== 1'b1) begin
      nFails++; $display("[TB] FAIL reset_mid_cooldown: got count %0d ack %b over %b blink %b, expected 0 0 0 1", penalty_num, foul_ack, game_over, blink_on);
    end
    applyStimulus(0, 0, 1, 0);
    nChecks++; if (penalty_num !== 4'd1) begin nFails++; $display("[TB] FAIL foul_after_reset: got %0d, expected 1", penalty_num); end
    for (int f = 1; f < MAXP; f++) begin
      for (int t = 0; t < COOL; t++) applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 1, 0);
    end
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    nChecks++; if (game_over !== 1'b0 || blink_on !== 1'b1) begin nFails++; $display("[TB] FAIL reset_mid_over: got over %b blink %b, expected 0 1", game_over, blink_on); end
    applyStimulus(0, 0, 1, 0);
    for (int t = 0; t < COOL - 1; t++) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0);
    nChecks++; if (penalty_num !== 4'd1) begin nFails++; $display("[TB] FAIL fresh_cooldown_after_over: got %0d, expected 1", penalty_num); end
  endtask

  task automatic test_foul_tick_expiry();
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    for (int t = 0; t < COOL - 1; t++) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1);
    nChecks++; if (penalty_num !== 4'd1 || foul_ack !== 1'b0) begin nFails++; $display("[TB] FAIL expiry_foul_dropped: got count %0d ack %b, expected 1 0", penalty_num, foul_ack); end
    applyStimulus(0, 0, 1, 0);
    nChecks++; if (penalty_num !== 4'd2 || foul_ack !== 1'b1) begin nFails++; $display("[TB] FAIL expiry_back_to_play: got count %0d ack %b, expected 2 1", penalty_num, foul_ack); end
  endtask

  task automatic test_random();
    applyStimulus(1, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      nChecks++; if (penalty_num !== 4'(mPen)) begin nFails++; $display("[TB] FAIL rand_count @%0d: got %0d, expected %0d", c, penalty_num, mPen); end
      nChecks++; if (foul_ack !== mAck) begin nFails++; $display("[TB] FAIL rand_ack @%0d: got %b, expected %b", c, foul_ack, mAck); end
      nChecks++; if (game_over !== (mPen == MAXP)) begin nFails++; $display("[TB] FAIL rand_game_over @%0d: got %b, expected %b", c, game_over, mPen == MAXP); end
      nChecks++; if (blink_on !== expBlink()) begin nFails++; $display("[TB] FAIL rand_blink @%0d: got %b, expected %b", c, blink_on, expBlink()); end
    end
  endtask

  initial begin
    reset = 1'b1; new_round = 1'b0; foul = 1'b0; tick = 1'b0;
    mPen = 0; mCool = 0; mOverTicks = 0; mAck = 1'b0;
    test_reset();
    test_first_foul();
    test_game_over();
    test_blink();
    test_new_round_priority();
    test_reset_mid_state();
    test_foul_tick_expiry();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/penalty_tracker.md
PENALTY_TRACKER -- requirements
Module: penalty_tracker

Interface
REQ-001 SHALL have parameter MAX_PENALTY, default 3, penalties allowed before game over (1..15).
REQ-002 SHALL have parameter COOLDOWN_TICKS, default 8, ticks during which new fouls are ignored after an accepted foul (1..255).
REQ-003 SHALL have parameter BLINK_TICKS, default 4, ticks per blink half-period in game-over (1..255).
REQ-004 SHALL have port clk, input, 1, system clock; the only clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port tick, input, 1, one-cycle slow time-base enable (frame rate).
REQ-007 SHALL have port foul, input, 1, one-cycle foul event pulse.
REQ-008 SHALL have port new_round, input, 1, one-cycle request to clear penalties and resume play.
REQ-009 SHALL have port penalty_num, output, 4, accepted penalty count, driving the penalty-marker renderer.
REQ-010 SHALL have port foul_ack, output, 1, one-cycle pulse on each accepted foul.
REQ-011 SHALL have port game_over, output, 1, high while in OVER.
REQ-012 SHALL have port blink_on, output, 1, marker-visible enable for the renderer.

Function
REQ-013 SHALL implement states PLAY, COOLDOWN, OVER.
REQ-014 In PLAY, foul=1 SHALL increment penalty_num on the next edge and pulse foul_ack for exactly that one cycle.
REQ-015 After an accepted foul with new count < MAX_PENALTY, SHALL enter COOLDOWN with timer loaded to COOLDOWN_TICKS.
REQ-016 After an accepted foul with new count == MAX_PENALTY, SHALL enter OVER with timer loaded to BLINK_TICKS and blink_on=1.
REQ-017 In COOLDOWN, SHALL decrement the timer on each tick; on the tick that reaches 0, SHALL return to PLAY.
REQ-018 Fouls in COOLDOWN or OVER SHALL be dropped: no count change, no foul_ack.
REQ-019 A foul and a tick in the same COOLDOWN cycle: the foul is dropped, the tick is counted.
REQ-020 In OVER, each tick SHALL decrement the timer; on reaching 0, SHALL toggle blink_on and reload BLINK_TICKS.
REQ-021 penalty_num SHALL saturate at MAX_PENALTY and never exceed it.
REQ-022 new_round=1 in any state SHALL, on the next edge, set penalty_num=0, blink_on=1, timer=0, state=PLAY.
REQ-023 new_round SHALL take priority over a same-cycle foul; that foul is dropped and foul_ack stays 0.
REQ-024 Outside OVER, blink_on SHALL be 1 and game_over 0.
REQ-025 All outputs SHALL be registered; foul-to-penalty_num latency is 1 clock.

Reset
REQ-026 reset SHALL set state=PLAY, penalty_num=0, foul_ack=0, game_over=0, blink_on=1, timer=0.
REQ-027 reset SHALL take priority over new_round, foul and tick.
REQ-028 reset asserted mid-COOLDOWN or mid-OVER SHALL abort that state with no residual timer effect.

Configuration
REQ-029 With macro PENALTY_BLINK_EN defined, OVER SHALL toggle blink_on per REQ-020.
REQ-030 Without PENALTY_BLINK_EN, blink_on SHALL be constant 1, and the OVER timer logic SHALL be removed; all other behaviour is unchanged.

Structure
REQ-031 A shared package penalty_pkg SHALL hold the state encoding (PLAY, COOLDOWN, OVER), the penalty width constant (4) and the timer width constant (8).
REQ-032 Sub-module penalty_timer SHALL provide the 8-bit loadable, tick-enabled down-counter with a zero flag, shared by COOLDOWN and OVER.

Verification
REQ-033 Bench SHALL cover: after reset, foul pulse -> penalty_num=1 and foul_ack one cycle next edge; 2nd foul within 8 ticks -> dropped, penalty_num stays 1.
REQ-034 Bench SHALL cover: 3 fouls each separated by >=8 ticks -> penalty_num=3 and game_over=1; further foul -> no change, no foul_ack.
REQ-035 Bench SHALL cover, with PENALTY_BLINK_EN: in OVER, blink_on toggles every 4 ticks (1,0,1 over 8 ticks); without the macro, blink_on stays 1.
REQ-036 Bench SHALL cover: foul and new_round in same cycle with penalty_num=2 -> penalty_num=0, foul_ack=0, state PLAY.
REQ-037 Bench SHALL cover: reset asserted during COOLDOWN at timer=5 -> all REQ-026 values next edge; an immediate foul is then accepted, giving penalty_num=1.
REQ-038 Bench SHALL cover: foul and tick in same cycle while timer=1 in COOLDOWN -> foul dropped, state returns to PLAY next edge.
